// File: rtl/se_tick_sync_if.sv
// Bus between the divided-clock receiver and its user: the slow level and
// prescaler controls in, the clk-domain enables and status out.
interface se_tick_sync_if #(
  parameter int CNT_W = 16
);
  logic             slow_clk_in;
  logic             enable;
  logic [3:0]       step_div;
  logic             tick;
  logic             step;
  logic             stalled;
  logic [CNT_W-1:0] tick_count;

  modport master (
    output slow_clk_in, enable, step_div,
    input  tick, step, stalled, tick_count
  );

  modport slave (
    input  slow_clk_in, enable, step_div,
    output tick, step, stalled, tick_count
  );
endinterface

// File: rtl/se_tick_sync.sv
// Turns a slow divided clock level into single-cycle clk-domain tick/step
// enables, with a tick counter and a stalled-divider watchdog.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_DISARMED | just out of reset; prev tracks the synchronizer, no ticks
// ST_ARMED    | rising edges of the synchronized level produce ticks
module se_tick_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 20000,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  se_tick_sync_if.slave bus
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam int              ARM_W    = 3;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_t;

  arm_state_t             state;
  arm_state_t             state_nxt;
  logic [ARM_W-1:0]       arm_cnt;
  logic [ARM_W-1:0]       arm_cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   prev;
  logic                   rise;
  logic                   tick;
  logic                   step_fire;
  logic [3:0]             step_cnt;
  logic [CNT_W-1:0]       tick_count;
  logic [WD_W-1:0]        wd_cnt;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_DISARMED;
      arm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
    end
  end

  // Disarmed for SYNC_STAGES+1 cycles so a level already high at reset
  // release reaches prev before edge detection starts.
  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    rise        = 1'b0;
    case (state)
      ST_DISARMED: begin
        arm_cnt_nxt = arm_cnt + ARM_W'(1);
        if (arm_cnt == ARM_LAST) state_nxt = ST_ARMED;
      end
      ST_ARMED: rise = sync_out & ~prev;
      default:  state_nxt = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= '0;
      prev       <= 1'b0;
      tick       <= 1'b0;
      wd_cnt     <= '0;
      tick_count <= '0;
      step_cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.slow_clk_in};
      prev <= sync_out;
      tick <= rise;

      // Clearing on the detected edge puts wd_cnt at 0 during the tick cycle.
      if (rise)                 wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);

      if (tick) tick_count <= tick_count + CNT_W'(1);

      if (tick && bus.enable) begin
        if (step_fire) step_cnt <= '0;
        else           step_cnt <= step_cnt + 4'd1;
      end
    end
  end

  assign step_fire      = (step_cnt >= bus.step_div);
  assign bus.tick       = tick;
  assign bus.step       = tick & bus.enable & step_fire;
  assign bus.stalled    = (wd_cnt == WD_MAX);
  assign bus.tick_count = tick_count;

endmodule

// File: tb/tb_se_tick_sync.sv
// Directed bench for se_tick_sync: stimulus queues the expected tick records,
// a negedge monitor pops and checks them whenever the DUT raises tick.
module tb_se_tick_sync;

  localparam int CNT_W = 4;

  typedef struct {
    int         cyc;
    logic       step;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] exp_cnt;

  se_tick_sync_if #(.CNT_W(CNT_W)) bus ();

  se_tick_sync #(
    .SYNC_STAGES(2),
    .TIMEOUT    (50),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One 20-cycle period of slow_clk_in; the tick is due 3 edges after capture.
  task automatic pulse(input logic exp_step);
    exp_t e;
    tick_clk(1);
    bus.slow_clk_in = 1'b1;
    e.cyc  = cyc_n + 3;
    e.step = exp_step;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    exp_cnt++;
    tick_clk(10);
    bus.slow_clk_in = 1'b0;
    tick_clk(9);
  endtask

  task automatic pulses(input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) pulse(pat[i]);
  endtask

  always @(negedge clk) begin
    if (bus.tick) begin
      if (sb.size() == 0) begin
        check("tick_unexpected", int'(bus.tick), 0);
      end else begin
        mon_e = sb.pop_front();
        check("tick_cycle", cyc_n, mon_e.cyc);
        check("step_at_tick", int'(bus.step), int'(mon_e.step));
        check("tick_count_at_tick", int'(bus.tick_count), int'(mon_e.cnt));
        check("stalled_at_tick", int'(bus.stalled), 0);
      end
    end else begin
      check("step_no_tick", int'(bus.step), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    exp_cnt         = '0;
    rst_n           = 1'b0;
    bus.slow_clk_in = 1'b0;
    bus.enable      = 1'b0;
    bus.step_div    = 4'd0;

    tick_clk(3);
    @(negedge clk);
    check("reset_tick", int'(bus.tick), 0);
    check("reset_step", int'(bus.step), 0);
    check("reset_stalled", int'(bus.stalled), 0);
    check("reset_tick_count", int'(bus.tick_count), 0);
    rst_n = 1'b1;

    // Watchdog from reset: low through cycle 49, high at cycle 50.
    repeat (49) @(posedge clk);
    @(negedge clk);
    check("wd_before_timeout", int'(bus.stalled), 0);
    @(negedge clk);
    check("wd_at_timeout", int'(bus.stalled), 1);
    tick_clk(5);
    check("wd_held", int'(bus.stalled), 1);

    // Basic ticks, prescaler disabled.
    pulses(5, 32'h0);
    check("count_after_5", int'(bus.tick_count), 5);
    check("no_stall_running", int'(bus.stalled), 0);

    // Prescaler divide-by-4, then hold, then resume from a held count of 0.
    bus.enable   = 1'b1;
    bus.step_div = 4'd3;
    pulses(12, 32'h888);
    bus.enable = 1'b0;
    pulses(4, 32'h0);
    bus.enable = 1'b1;
    pulses(4, 32'h8);
    check("count_wrapped_25", int'(bus.tick_count), 9);

    // Lowering the divisor below the running count fires on the next tick.
    bus.step_div = 4'd7;
    pulses(5, 32'h0);
    bus.step_div = 4'd2;
    pulses(4, 32'h9);

    // Reset while an edge is in flight and the input stays high: no tick.
    tick_clk(1);
    bus.slow_clk_in = 1'b1;
    tick_clk(1);
    rst_n = 1'b0;
    tick_clk(1);
    rst_n   = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    check("midreset_tick", int'(bus.tick), 0);
    check("midreset_step", int'(bus.step), 0);
    check("midreset_stalled", int'(bus.stalled), 0);
    check("midreset_tick_count", int'(bus.tick_count), 0);
    tick_clk(20);
    check("high_at_release_count", int'(bus.tick_count), 0);
    bus.slow_clk_in = 1'b0;
    tick_clk(10);

    bus.enable   = 1'b1;
    bus.step_div = 4'd0;
    pulses(1, 32'h1);
    check("first_real_edge_count", int'(bus.tick_count), 1);
    pulses(16, 32'hFFFF);
    check("count_after_17", int'(bus.tick_count), 1);

    tick_clk(1);
    rst_n = 1'b0;
    tick_clk(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("final_reset_tick", int'(bus.tick), 0);
    check("final_reset_step", int'(bus.step), 0);
    check("final_reset_stalled", int'(bus.stalled), 0);
    check("final_reset_tick_count", int'(bus.tick_count), 0);

    tick_clk(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
